// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer: steps an 8x8 by 8x8 byte matrix product through a
// combinational 2x8-by-8x2 kernel, one 2x2 output tile per pass (16 tiles).
// Each pass fetches two A rows and two B columns, lets the kernel settle,
// then writes the four 16-bit products big-endian into the result RAM.
module matmul_tile_sequencer #(
  parameter int KLAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic [3:0]   tile,
  output logic         rd_en,
  output logic [5:0]   a_rd_addr,
  output logic [5:0]   b_rd_addr,
  input  logic [7:0]   a_rd_data,
  input  logic [7:0]   b_rd_data,
  output logic [127:0] kern_a,
  output logic [127:0] kern_b,
  input  logic [63:0]  kern_c,
  output logic         c_wr_en,
  output logic [6:0]   c_wr_addr,
  output logic [7:0]   c_wr_data
);

  // One counter serves the 16 fetch steps, KLAT+1 compute cycles and 8 writes.
  localparam int CW = $clog2(KLAT + 17);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_COMPUTE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [3:0]     tile_q;
  logic           busy_q;
  logic           done_q;
  logic           rd_en_q;
  logic [5:0]     a_addr_q;
  logic [5:0]     b_addr_q;
  logic [127:0]   ka_q;
  logic [127:0]   kb_q;
  logic [63:0]    c_q;
  logic           wr_en_q;
  logic [6:0]     wr_addr_q;
  logic [7:0]     wr_data_q;

  logic [3:0]     fetch_j_d;   // fetch step that follows the current one
  logic [3:0]     cap_slot_d;  // operand slot whose read data is on the bus now
  logic [6:0]     cap_lsb_d;   // bit position of that slot (slot 0 sits in the MSBs)
  logic [2:0]     wr_idx_d;    // result byte that follows the current one
  logic [5:0]     wr_lsb_d;    // bit position of that byte within the captured products
  logic [3:0]     tile_d;

  // Row pair r = t[3:2]; first 8 steps read row 2r, next 8 read row 2r+1.
  function automatic logic [5:0] a_addr_f(input logic [3:0] t, input logic [3:0] j);
    return {t[3:2], j};
  endfunction

  // Column 2cp for the first 8 steps, 2cp+1 for the next 8; k = j[2:0].
  function automatic logic [5:0] b_addr_f(input logic [3:0] t, input logic [3:0] j);
    return {j[2:0], t[1:0], j[3]};
  endfunction

  // Byte n of a tile: 32r + 4cp + n for n<4, and 16 bytes further on for the lower row.
  function automatic logic [6:0] c_addr_f(input logic [3:0] t, input logic [2:0] n);
    return {t[3:2], n[2], t[1:0], n[1:0]};
  endfunction

  // Index arithmetic for the next fetch step, capture slot and write byte.
  always_comb begin
    fetch_j_d  = cnt_q[3:0] + 4'd1;
    cap_slot_d = (state_q == S_DRAIN) ? 4'd15 : (cnt_q[3:0] - 4'd1);
    cap_lsb_d  = 7'd120 - {cap_slot_d, 3'b000};
    wr_idx_d   = cnt_q[2:0] + 3'd1;
    wr_lsb_d   = 6'd56 - {wr_idx_d, 3'b000};
    tile_d     = tile_q + 4'd1;
  end

  // Sequencer FSM with all outputs registered; abort drops to IDLE from any busy state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tile_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      ka_q      <= '0;
      kb_q      <= '0;
      c_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (abort && state_q != S_IDLE) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_q  <= S_FETCH;
            cnt_q    <= '0;
            tile_q   <= 4'd0;
            busy_q   <= 1'b1;
            rd_en_q  <= 1'b1;
            a_addr_q <= a_addr_f(4'd0, 4'd0);
            b_addr_q <= b_addr_f(4'd0, 4'd0);
          end
        end
        S_FETCH: begin
          // Data for the previous step arrives one cycle after its strobe.
          if (cnt_q[3:0] != 4'd0) begin
            ka_q[cap_lsb_d +: 8] <= a_rd_data;
            kb_q[cap_lsb_d +: 8] <= b_rd_data;
          end
          if (cnt_q[3:0] == 4'd15) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q    <= CW'(fetch_j_d);
            a_addr_q <= a_addr_f(tile_q, fetch_j_d);
            b_addr_q <= b_addr_f(tile_q, fetch_j_d);
          end
        end
        S_DRAIN: begin
          ka_q[cap_lsb_d +: 8] <= a_rd_data;
          kb_q[cap_lsb_d +: 8] <= b_rd_data;
          state_q <= S_COMPUTE;
          cnt_q   <= '0;
        end
        S_COMPUTE: begin
          // First result byte comes straight from the kernel; the rest from c_q.
          if (cnt_q == CW'(KLAT)) begin
            c_q       <= kern_c;
            wr_en_q   <= 1'b1;
            wr_addr_q <= c_addr_f(tile_q, 3'd0);
            wr_data_q <= kern_c[63:56];
            cnt_q     <= '0;
            state_q   <= S_WRITE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WRITE: begin
          if (cnt_q[2:0] == 3'd7) begin
            wr_en_q <= 1'b0;
            if (tile_q == 4'd15) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              tile_q   <= tile_d;
              state_q  <= S_FETCH;
              cnt_q    <= '0;
              rd_en_q  <= 1'b1;
              a_addr_q <= a_addr_f(tile_d, 4'd0);
              b_addr_q <= b_addr_f(tile_d, 4'd0);
            end
          end else begin
            cnt_q     <= cnt_q + CW'(1);
            wr_addr_q <= c_addr_f(tile_q, wr_idx_d);
            wr_data_q <= c_q[wr_lsb_d +: 8];
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign tile      = tile_q;
  assign rd_en     = rd_en_q;
  assign a_rd_addr = a_addr_q;
  assign b_rd_addr = b_addr_q;
  assign kern_a    = ka_q;
  assign kern_b    = kb_q;
  assign c_wr_en   = wr_en_q;
  assign c_wr_addr = wr_addr_q;
  assign c_wr_data = wr_data_q;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Bench for matmul_tile_sequencer: two instances (KLAT=0 and KLAT=3) share the
// operand memories; each has its own 1-cycle read model and kernel model.
// Cycle n is the clock period ending at edge n; start is sampled at edge 0.
module tb_matmul_tile_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst_n_v;
  logic [1:0]        start_v;
  logic [1:0]        abort_v;
  logic [1:0]        busy_v;
  logic [1:0]        done_v;
  logic [1:0]        rd_en_v;
  logic [1:0]        c_wr_en_v;
  logic [1:0][3:0]   tile_v;
  logic [1:0][5:0]   a_addr_v;
  logic [1:0][5:0]   b_addr_v;
  logic [1:0][7:0]   a_data_v;
  logic [1:0][7:0]   b_data_v;
  logic [1:0][127:0] ka_v;
  logic [1:0][127:0] kb_v;
  logic [1:0][63:0]  kc_v;
  logic [1:0][6:0]   c_addr_v;
  logic [1:0][7:0]   c_data_v;

  logic [7:0] a_mem [64];
  logic [7:0] b_mem [64];

  int checks = 0;
  int passes = 0;

  // Kernel: c00 = rowA0.colB0, c01 = rowA0.colB1, c10 = rowA1.colB0, c11 = rowA1.colB1.
  function automatic logic [63:0] kernel_model(input logic [127:0] a, input logic [127:0] b);
    logic [15:0] acc [4];
    logic [15:0] pa;
    logic [15:0] pb;
    for (int q = 0; q < 4; q++) begin
      acc[q] = 16'd0;
      for (int k = 0; k < 8; k++) begin
        pa = {8'h00, a[127 - 8*(8*(q/2) + k) -: 8]};
        pb = {8'h00, b[127 - 8*(8*(q%2) + k) -: 8]};
        acc[q] = acc[q] + pa * pb;
      end
    end
    return {acc[0], acc[1], acc[2], acc[3]};
  endfunction

  // Reference result byte straight from the matrices: word (i,j) big-endian at 16i+2j.
  function automatic logic [7:0] ref_byte(input int addr);
    int i;
    int j;
    logic [15:0] w;
    logic [15:0] pa;
    logic [15:0] pb;
    i = addr / 16;
    j = (addr % 16) / 2;
    w = 16'd0;
    for (int k = 0; k < 8; k++) begin
      pa = {8'h00, a_mem[8*i + k]};
      pb = {8'h00, b_mem[8*k + j]};
      w = w + pa * pb;
    end
    return (addr % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unit
      matmul_tile_sequencer #(.KLAT(3*gi)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n_v[gi]),
        .start     (start_v[gi]),
        .abort     (abort_v[gi]),
        .busy      (busy_v[gi]),
        .done      (done_v[gi]),
        .tile      (tile_v[gi]),
        .rd_en     (rd_en_v[gi]),
        .a_rd_addr (a_addr_v[gi]),
        .b_rd_addr (b_addr_v[gi]),
        .a_rd_data (a_data_v[gi]),
        .b_rd_data (b_data_v[gi]),
        .kern_a    (ka_v[gi]),
        .kern_b    (kb_v[gi]),
        .kern_c    (kc_v[gi]),
        .c_wr_en   (c_wr_en_v[gi]),
        .c_wr_addr (c_addr_v[gi]),
        .c_wr_data (c_data_v[gi])
      );
      assign kc_v[gi] = kernel_model(ka_v[gi], kb_v[gi]);
    end
  endgenerate

  // Operand RAMs: registered read, data valid the cycle after rd_en.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rd_en_v[u]) begin
        a_data_v[u] <= a_mem[a_addr_v[u]];
        b_data_v[u] <= b_mem[b_addr_v[u]];
      end
    end
  end

  task automatic load_identity_ramp();
    for (int x = 0; x < 64; x++) begin
      a_mem[x] = (x / 8 == x % 8) ? 8'd1 : 8'd0;
      b_mem[x] = 8'(x);
    end
  endtask

  task automatic load_ones_twos();
    for (int x = 0; x < 64; x++) begin
      a_mem[x] = 8'd1;
      b_mem[x] = 8'd2;
    end
  endtask

  task automatic load_mixed();
    for (int x = 0; x < 64; x++) begin
      a_mem[x] = 8'(x * 37 + 11);
      b_mem[x] = 8'(x * 91 + 200);
    end
  endtask

  // Full multiply on unit u, recording the result-RAM writes and timing.
  task automatic run_mult(input int u, input int exp_first, input int period,
                          input int exp_done, input int restart_cyc, input string nm);
    logic [7:0] got [128];
    logic       seen [128];
    int first_rd, first_wr, nwr, ndone, done_cyc;
    int bad_wr, bad_tile, bad_busy, bad_bytes, bad_addr, off;
    logic exp_wr;
    logic [7:0] rb;
    first_rd = -1; first_wr = -1; nwr = 0; ndone = 0; done_cyc = -1;
    bad_wr = 0; bad_tile = 0; bad_busy = 0; bad_bytes = 0; bad_addr = -1;
    for (int i = 0; i < 128; i++) begin
      got[i] = 8'h00;
      seen[i] = 1'b0;
    end
    @(negedge clk);
    start_v[u] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= exp_done + 10; n++) begin
      #1;
      start_v[u] = (n == restart_cyc);
      @(negedge clk);
      if (rd_en_v[u] && first_rd < 0) first_rd = n;
      off = n - exp_first;
      exp_wr = (off >= 0) && (off / period < 16) && (off % period < 8);
      if (c_wr_en_v[u] !== exp_wr) bad_wr++;
      if (c_wr_en_v[u] === 1'b1) begin
        nwr++;
        if (first_wr < 0) first_wr = n;
        got[c_addr_v[u]] = c_data_v[u];
        seen[c_addr_v[u]] = 1'b1;
        if (exp_wr && tile_v[u] !== 4'(off / period)) bad_tile++;
      end
      if (done_v[u] === 1'b1) begin
        ndone++;
        done_cyc = n;
        if (busy_v[u] !== 1'b0) bad_busy++;
      end
      @(posedge clk);
    end
    start_v[u] = 1'b0;
    for (int i = 0; i < 128; i++) begin
      rb = ref_byte(i);
      if (!seen[i] || got[i] !== rb) begin
        if (bad_addr < 0) bad_addr = i;
        bad_bytes++;
      end
    end
    checks++;
    if (first_rd !== 1) $display("FAIL %s first_rd: got cycle %0d, expected 1", nm, first_rd);
    else passes++;
    checks++;
    if (first_wr !== exp_first) $display("FAIL %s first_wr: got cycle %0d, expected %0d", nm, first_wr, exp_first);
    else passes++;
    checks++;
    if (nwr !== 128) $display("FAIL %s write_count: got %0d, expected 128", nm, nwr);
    else passes++;
    checks++;
    if (ndone !== 1) $display("FAIL %s done_pulses: got %0d, expected 1", nm, ndone);
    else passes++;
    checks++;
    if (done_cyc !== exp_done) $display("FAIL %s done_cycle: got %0d, expected %0d", nm, done_cyc, exp_done);
    else passes++;
    checks++;
    if (bad_wr !== 0) $display("FAIL %s wr_timing: got %0d off-schedule cycles, expected 0", nm, bad_wr);
    else passes++;
    checks++;
    if (bad_tile !== 0) $display("FAIL %s tile_seq: got %0d wrong tile values, expected 0", nm, bad_tile);
    else passes++;
    checks++;
    if (bad_busy !== 0) $display("FAIL %s busy_at_done: got %0d cycles busy, expected 0", nm, bad_busy);
    else passes++;
    checks++;
    if (bad_bytes !== 0)
      $display("FAIL %s results: got %0d bad bytes (first addr %0d got %02h), expected 0",
               nm, bad_bytes, bad_addr, got[bad_addr]);
    else passes++;
    $display("%s: writes=%0d first_wr=%0d done=%0d bad_bytes=%0d", nm, nwr, first_wr, done_cyc, bad_bytes);
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({busy_v[u], done_v[u], rd_en_v[u], c_wr_en_v[u], tile_v[u], a_addr_v[u],
           b_addr_v[u], c_addr_v[u], c_data_v[u]} !== 35'd0)
        $display("FAIL reset_ctrl unit%0d: got busy=%b rd=%b wr=%b tile=%0d, expected all 0",
                 u, busy_v[u], rd_en_v[u], c_wr_en_v[u], tile_v[u]);
      else passes++;
      checks++;
      if ({ka_v[u], kb_v[u]} !== 256'd0)
        $display("FAIL reset_kern unit%0d: got kern_a=%h, expected 0", u, ka_v[u]);
      else passes++;
    end
    rst_n_v = 2'b11;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_v !== 2'b00) $display("FAIL idle_after_reset: got busy=%b, expected 00", busy_v);
    else passes++;
    $display("reset: busy=%b rd_en=%b", busy_v, rd_en_v);
  endtask

  task automatic test_abort_start_idle();
    @(negedge clk);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b0 || rd_en_v[0] !== 1'b0)
      $display("FAIL abort_start_idle: got busy=%b rd_en=%b, expected 0 0", busy_v[0], rd_en_v[0]);
    else passes++;
    $display("abort_start_idle: busy=%b rd_en=%b", busy_v[0], rd_en_v[0]);
    repeat (3) @(posedge clk);
  endtask

  task automatic test_abort();
    int pre, post, ndone;
    logic busy61, rd61;
    logic [3:0] tile60;
    pre = 0; post = 0; ndone = 0; busy61 = 1'b1; rd61 = 1'b1; tile60 = 4'd0;
    load_mixed();
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 470; n++) begin
      #1;
      start_v[0] = 1'b0;
      abort_v[0] = (n == 60);
      @(negedge clk);
      if (n == 60) tile60 = tile_v[0];
      if (n == 61) begin
        busy61 = busy_v[0];
        rd61 = rd_en_v[0];
      end
      if (c_wr_en_v[0] === 1'b1) begin
        if (n <= 60) pre++;
        else post++;
      end
      if (done_v[0] === 1'b1) ndone++;
      @(posedge clk);
    end
    abort_v[0] = 1'b0;
    checks++;
    if (tile60 !== 4'd2) $display("FAIL abort_tile: got %0d, expected 2", tile60);
    else passes++;
    checks++;
    if (busy61 !== 1'b0 || rd61 !== 1'b0)
      $display("FAIL abort_stop: got busy=%b rd_en=%b in cycle 61, expected 0 0", busy61, rd61);
    else passes++;
    checks++;
    if (pre !== 16) $display("FAIL abort_pre_writes: got %0d, expected 16", pre);
    else passes++;
    checks++;
    if (post !== 0) $display("FAIL abort_post_writes: got %0d, expected 0", post);
    else passes++;
    checks++;
    if (ndone !== 0) $display("FAIL abort_done: got %0d pulses, expected 0", ndone);
    else passes++;
    $display("abort: pre=%0d post=%0d done=%0d", pre, post, ndone);
    run_mult(0, 19, 26, 417, -1, "after_abort");
  endtask

  task automatic test_midrun_reset();
    logic saw_wr20;
    logic [34:0] ctrl21;
    logic [255:0] kern21;
    int bad_busy;
    saw_wr20 = 1'b0; ctrl21 = '1; kern21 = '1; bad_busy = 0;
    load_mixed();
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      #1;
      if (n == 1) start_v[0] = 1'b0;
      if (n == 20) begin
        rst_n_v[0] = 1'b0;
        start_v[0] = 1'b1;
      end
      if (n == 23) begin
        rst_n_v[0] = 1'b1;
        start_v[0] = 1'b0;
      end
      @(negedge clk);
      if (n == 20) saw_wr20 = c_wr_en_v[0];
      if (n == 21) begin
        ctrl21 = {busy_v[0], done_v[0], rd_en_v[0], c_wr_en_v[0], tile_v[0], a_addr_v[0],
                  b_addr_v[0], c_addr_v[0], c_data_v[0]};
        kern21 = {ka_v[0], kb_v[0]};
      end
      if (n >= 21 && (busy_v[0] !== 1'b0 || rd_en_v[0] !== 1'b0)) bad_busy++;
      @(posedge clk);
    end
    checks++;
    if (saw_wr20 !== 1'b1) $display("FAIL rst_in_write: got c_wr_en=%b in cycle 20, expected 1", saw_wr20);
    else passes++;
    checks++;
    if (ctrl21 !== 35'd0) $display("FAIL rst_ctrl_clear: got %h, expected 0", ctrl21);
    else passes++;
    checks++;
    if (kern21 !== 256'd0) $display("FAIL rst_kern_clear: got %h, expected 0", kern21);
    else passes++;
    checks++;
    if (bad_busy !== 0) $display("FAIL rst_start_ignored: got %0d busy cycles, expected 0", bad_busy);
    else passes++;
    $display("midrun_reset: ctrl21=%h busy_cycles=%0d", ctrl21, bad_busy);
  endtask

  initial begin
    rst_n_v = 2'b00;
    start_v = 2'b00;
    abort_v = 2'b00;
    repeat (3) @(posedge clk);
    test_reset();
    load_identity_ramp();
    run_mult(0, 19, 26, 417, -1, "identity_ramp");
    load_ones_twos();
    run_mult(0, 19, 26, 417, -1, "ones_twos");
    load_mixed();
    run_mult(1, 22, 29, 465, -1, "klat3");
    load_identity_ramp();
    run_mult(0, 19, 26, 417, 100, "start_while_busy");
    test_abort_start_idle();
    test_abort();
    test_midrun_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
